// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI flash-read sequencer: register map, lane types,
// opcodes, sequencer states and the wrapper request record.
package qspi_pkg;

  typedef enum logic [2:0] {
    REG_CFG0 = 3'd0,
    REG_CFG1 = 3'd1,
    REG_DATA = 3'd2
  } reg_e;

  typedef enum logic [1:0] {
    LN_SINGLE = 2'b00,
    LN_DUAL   = 2'b01,
    LN_QUAD   = 2'b10
  } lane_e;

  typedef enum logic [7:0] {
    OP_READ  = 8'h03,
    OP_QREAD = 8'h6B
  } op_e;

  typedef enum logic [3:0] {
    IDLE,
    CFG,
    CSN_LO,
    CMD,
    ADDR,
    QCFG_D,
    DUMMY,
    QCFG_Q,
    DATA,
    CSN_HI
  } state_e;

  typedef struct packed {
    logic [2:0] addr;
    logic       read;
    logic [7:0] dat;
  } req_t;

endpackage

// File: rtl/qspi_req_slot.sv
// Single outstanding wrapper transaction: holds request fields, REQ/RSP phase
// and reports request/response handshake completion to the sequencer FSM.
module qspi_req_slot
  import qspi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  req_t issue_req,
  input  logic req_rdy,
  input  logic rsp_vld,
  input  logic rsp_rdy,
  output logic req_vld,
  output req_t req,
  output logic rsp_phase,
  output logic req_done,
  output logic rsp_done
);

  assign req_done = req_vld & req_rdy;
  assign rsp_done = rsp_phase & rsp_vld & rsp_rdy;

  // A new issue always coincides with the previous response completing, so it
  // takes priority and re-enters REQ phase directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld   <= 1'b0;
      rsp_phase <= 1'b0;
      req       <= '0;
    end else if (issue) begin
      req_vld   <= 1'b1;
      rsp_phase <= 1'b0;
      req       <= issue_req;
    end else if (req_done) begin
      req_vld   <= 1'b0;
      rsp_phase <= 1'b1;
    end else if (rsp_done) begin
      rsp_phase <= 1'b0;
    end
  end

endmodule

// File: rtl/qspi_rd_seq.sv
// Flash-read sequencer: expands one host read command into the wrapper register
// transaction sequence. Quad fast read is built only with QSPI_RD_SEQ_QUAD_EN.
module qspi_rd_seq
  import qspi_pkg::*;
#(
  parameter int         LEN_W = 8,
  parameter logic [3:0] DIV   = 4'd2,
  parameter logic [1:0] MODE  = 2'b00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [23:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_quad,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [7:0]       rd_dat,
  output logic             rd_last,
  output logic             busy,
  output logic             qspi_if_req_vld,
  input  logic             qspi_if_req_rdy,
  output logic [2:0]       qspi_if_req_addr,
  output logic             qspi_if_req_read,
  output logic [7:0]       qspi_if_req_dat,
  input  logic             qspi_if_rsp_vld,
  output logic             qspi_if_rsp_rdy,
  input  logic [7:0]       qspi_if_rsp_dat
);

  state_e           state, state_nxt;
  logic [1:0]       cnt_addr, sel_nxt;
  logic [LEN_W-1:0] cnt_len;
  logic [23:0]      addr_r;
  logic [7:0]       op;
  logic             issue, rsp_phase, rsp_rdy, req_done, rsp_done, data_rsp;
  req_t             issue_req, slot_req;

`ifdef QSPI_RD_SEQ_QUAD_EN
  logic quad_r;

  always_ff @(posedge clk) begin
    if (rst)                         quad_r <= 1'b0;
    else if (state == IDLE && cmd_vld) quad_r <= cmd_quad;
  end

  assign op = quad_r ? OP_QREAD : OP_READ;
`else
  logic unused_quad;
  assign unused_quad = cmd_quad;
  assign op          = OP_READ;
`endif

  // Request fields for the transaction about to be issued in state st.
  function automatic req_t req_for(state_e st, logic [1:0] sel, logic [7:0] opc,
                                   logic [23:0] a);
    req_t r;
    r = '0;
    case (st)
      CFG: begin
        r.addr = REG_CFG0;
        r.dat  = {MODE, 1'b0, LN_SINGLE, 3'b000};
      end
      CSN_LO: begin
        r.addr = REG_CFG1;
        r.dat  = {DIV, 1'b0, 3'b000};
      end
      CMD: begin
        r.addr = REG_DATA;
        r.dat  = opc;
      end
      ADDR: begin
        r.addr = REG_DATA;
        case (sel)
          2'd0:    r.dat = a[23:16];
          2'd1:    r.dat = a[15:8];
          default: r.dat = a[7:0];
        endcase
      end
`ifdef QSPI_RD_SEQ_QUAD_EN
      QCFG_D: begin
        r.addr = REG_CFG0;
        r.dat  = {MODE, 1'b1, LN_SINGLE, 3'b000};
      end
      DUMMY: begin
        r.addr = REG_DATA;
        r.dat  = 8'h00;
      end
      QCFG_Q: begin
        r.addr = REG_CFG0;
        r.dat  = {MODE, 1'b0, LN_QUAD, 3'b000};
      end
`endif
      DATA: begin
        r.addr = REG_DATA;
        r.read = 1'b1;
      end
      CSN_HI: begin
        r.addr = REG_CFG1;
        r.dat  = {DIV, 1'b1, 3'b000};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt_addr <= 2'd0;
      cnt_len  <= '0;
      addr_r   <= '0;
    end else begin
      state    <= state_nxt;
      cnt_addr <= sel_nxt;
      if (state == IDLE && cmd_vld) begin
        addr_r  <= cmd_addr;
        cnt_len <= cmd_len;
      end else if (state == DATA && rsp_done && cnt_len != '0) begin
        cnt_len <= cnt_len - LEN_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = cnt_addr;
    case (state)
      IDLE:   if (cmd_vld) state_nxt = CFG;
      CFG:    if (rsp_done) state_nxt = CSN_LO;
      CSN_LO: if (rsp_done) state_nxt = CMD;
      CMD: begin
        if (rsp_done) begin
          state_nxt = ADDR;
          sel_nxt   = 2'd0;
        end
      end
      ADDR: begin
        if (rsp_done) begin
          if (cnt_addr == 2'd2) begin
`ifdef QSPI_RD_SEQ_QUAD_EN
            state_nxt = quad_r ? QCFG_D : DATA;
`else
            state_nxt = DATA;
`endif
          end else begin
            sel_nxt = cnt_addr + 2'd1;
          end
        end
      end
`ifdef QSPI_RD_SEQ_QUAD_EN
      QCFG_D: if (rsp_done) state_nxt = DUMMY;
      DUMMY:  if (rsp_done) state_nxt = QCFG_Q;
      QCFG_Q: if (rsp_done) state_nxt = DATA;
`endif
      DATA:   if (rsp_done && cnt_len == '0) state_nxt = CSN_HI;
      CSN_HI: if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Next transaction is issued on the same edge the previous one completes.
    issue = (state == IDLE) ? cmd_vld : (rsp_done && state_nxt != IDLE);
  end

  // CFG fields are address independent, so registered command fields suffice.
  assign issue_req = req_for(state_nxt, sel_nxt, op, addr_r);

  qspi_req_slot u_slot (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .issue_req (issue_req),
    .req_rdy   (qspi_if_req_rdy),
    .rsp_vld   (qspi_if_rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .req_vld   (qspi_if_req_vld),
    .req       (slot_req),
    .rsp_phase (rsp_phase),
    .req_done  (req_done),
    .rsp_done  (rsp_done)
  );

  // Read bytes pass straight from the wrapper response to the sink.
  assign data_rsp = rsp_phase && state == DATA;
  assign rsp_rdy  = rsp_phase && (state != DATA || rd_rdy);
  assign rd_vld   = data_rsp && qspi_if_rsp_vld;
  assign rd_dat   = data_rsp ? qspi_if_rsp_dat : 8'h00;
  assign rd_last  = data_rsp && cnt_len == '0;

  assign qspi_if_rsp_rdy  = rsp_rdy;
  assign qspi_if_req_addr = slot_req.addr;
  assign qspi_if_req_read = slot_req.read;
  assign qspi_if_req_dat  = slot_req.dat;
  assign cmd_rdy          = state == IDLE;
  assign busy             = state != IDLE;

  logic unused_req_done;
  assign unused_req_done = req_done;

endmodule
